// File: rtl/dispense_pkg.sv
// Shared dispenser definitions: scheduler state encoding
// and default pulse/gap timing used by the clock/timer blocks.
package dispense_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FIRE = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam int PULSE_1S  = 50000000;
  localparam int GAP_200MS = 10000000;

endpackage

// File: rtl/dispense_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above
// i_ptr, wrapping. Ports: i_req, i_ptr in; o_gnt (one-hot), o_idx out.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_j;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N))
        w_sum = w_sum - (PW+1)'(N);
      w_j = w_sum[PW-1:0];
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/dispense_scheduler.sv
// Turns slot edges + manual requests into pending doses and fires
// them one at a time. Ports: CLOCK_50, reset(n), slot levels, per-module
// schedule masks, manual_req in; port, busy, pending, dup_err out.
module dispense_scheduler
  import dispense_pkg::*;
#(
  parameter int NUM_MODULES  = 2,
  parameter int PULSE_CYCLES = PULSE_1S,
  parameter int GAP_CYCLES   = GAP_200MS,
  parameter int CNT_W        = 31
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   morningP,
  input  logic                   afternoonP,
  input  logic                   eveningP,
  input  logic [NUM_MODULES-1:0] sched_m,
  input  logic [NUM_MODULES-1:0] sched_a,
  input  logic [NUM_MODULES-1:0] sched_e,
  input  logic [NUM_MODULES-1:0] manual_req,
  output logic [NUM_MODULES-1:0] port,
  output logic                   busy,
  output logic [NUM_MODULES-1:0] pending,
  output logic                   dup_err
);

  localparam int N  = NUM_MODULES;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_ptr;
  logic [N-1:0]     r_port;
  logic             r_busy;
  logic [N-1:0]     r_pending;
  logic             r_dup;
  logic [2:0]       r_slot_q;
  logic [2:0]       r_slot_d;

  logic [2:0]       w_edge;
  logic [N-1:0]     w_req;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_gnt;
  logic [PW-1:0]    w_idx;

  // Slot index 0/1/2 = morning/afternoon/evening
  assign w_edge = r_slot_q & ~r_slot_d;

  assign w_req = ({N{w_edge[0]}} & sched_m)
               | ({N{w_edge[1]}} & sched_a)
               | ({N{w_edge[2]}} & sched_e)
               | manual_req;

  assign w_clr = (r_state == IDLE) ? w_gnt : '0;

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .i_req (r_pending),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_slot_q  <= '0;
      r_slot_d  <= '0;
      r_pending <= '0;
      r_dup     <= 1'b0;
    end else begin
      r_slot_q  <= {eveningP, afternoonP, morningP};
      r_slot_d  <= r_slot_q;
      // A new request in the clearing cycle re-arms the flag
      r_pending <= (r_pending & ~w_clr) | w_req;
      if (|(w_req & r_pending & ~w_clr))
        r_dup <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_port  <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_port <= '0;
          if (|r_pending) begin
            r_cnt   <= '0;
            r_port  <= w_gnt;
            r_ptr   <= (w_idx == PW'(N-1)) ? '0 : w_idx + PW'(1);
            r_busy  <= 1'b1;
            r_state <= FIRE;
          end
        end
        FIRE: begin
          if (r_cnt == P_LAST) begin
            r_cnt   <= '0;
            r_port  <= '0;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          r_port <= '0;
          if (r_cnt == G_LAST) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_port  <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign port    = r_port;
  assign busy    = r_busy;
  assign pending = r_pending;
  assign dup_err = r_dup;

endmodule

// File: tb/tb_dispense_scheduler.sv
// Directed bench for dispense_scheduler with 2 modules,
// 4-cycle pulses and 3-cycle gaps.
module tb_dispense_scheduler;

  logic       clk;
  logic       rst_n;
  logic       mP, aP, eP;
  logic [1:0] s_m, s_a, s_e;
  logic [1:0] man;
  logic [1:0] port;
  logic       busy;
  logic [1:0] pend;
  logic       dup;

  int n_checks;
  int n_err;

  dispense_scheduler #(
    .NUM_MODULES  (2),
    .PULSE_CYCLES (4),
    .GAP_CYCLES   (3),
    .CNT_W        (8)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (rst_n),
    .morningP   (mP),
    .afternoonP (aP),
    .eveningP   (eP),
    .sched_m    (s_m),
    .sched_a    (s_a),
    .sched_e    (s_e),
    .manual_req (man),
    .port       (port),
    .busy       (busy),
    .pending    (pend),
    .dup_err    (dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read there too
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [1:0] ep;
  int         st0, st1;
  logic [1:0] prv;

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n = 1'b0;
    mP = 0; aP = 0; eP = 0;
    s_m = '0; s_a = '0; s_e = '0;
    man = '0;

    // Reset state
    @(negedge clk);
    chk("rst_port", 32'(port), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_dup",  32'(dup),  0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_port", 32'(port), 0);

    // Single manual dose on module 0
    man = 2'b01;
    tick();
    man = 2'b00;
    chk("m0_pend1", 32'(pend), 32'h1);
    chk("m0_port1", 32'(port), 0);
    for (int k = 2; k <= 9; k++) begin
      tick();
      ep = (k <= 5) ? 2'b01 : 2'b00;
      chk($sformatf("m0_port@%0d", k), 32'(port), 32'(ep));
      chk($sformatf("m0_busy@%0d", k), 32'(busy), (k <= 8) ? 1 : 0);
    end
    chk("m0_pend_end", 32'(pend), 0);

    // Both requested with pointer at 1: module 1 first
    man = 2'b11;
    tick();
    man = 2'b00;
    chk("rr_pend1", 32'(pend), 32'h3);
    for (int k = 2; k <= 14; k++) begin
      tick();
      if (k >= 2 && k <= 5)       ep = 2'b10;
      else if (k >= 10 && k <= 13) ep = 2'b01;
      else                         ep = 2'b00;
      chk($sformatf("rr_port@%0d", k), 32'(port), 32'(ep));
    end
    for (int k = 0; k < 4; k++) tick();
    chk("rr_busy_end", 32'(busy), 0);
    chk("rr_dup_end",  32'(dup),  0);

    // Duplicate request for module 0 while module 1 fires
    man = 2'b11;
    tick();
    man = 2'b00;
    tick();
    chk("dup_port_m1", 32'(port), 32'h2);
    chk("dup_pend0",   32'(pend), 32'h1);
    man = 2'b01;
    tick();
    chk("dup_flag", 32'(dup), 1);
    tick();
    man = 2'b00;
    st0 = 0;
    st1 = 0;
    prv = port;
    for (int k = 0; k < 22; k++) begin
      tick();
      if (port[0] && !prv[0]) st0++;
      if (port[1] && !prv[1]) st1++;
      prv = port;
    end
    chk("dup_m0_doses", 32'(st0), 1);
    chk("dup_m1_doses", 32'(st1), 0);
    chk("dup_sticky",   32'(dup), 1);
    chk("dup_pend_end", 32'(pend), 0);

    // Request in the same cycle module 0 is granted
    man = 2'b01;
    tick();
    chk("re_pend1", 32'(pend), 32'h1);
    tick();
    man = 2'b00;
    chk("re_port2", 32'(port), 32'h1);
    chk("re_pend2", 32'(pend), 32'h1);
    for (int k = 3; k <= 9; k++) tick();
    chk("re_port9",  32'(port), 0);
    tick();
    chk("re_port10", 32'(port), 32'h1);
    chk("re_pend10", 32'(pend), 0);
    for (int k = 0; k < 10; k++) tick();
    chk("re_idle", 32'(busy), 0);

    // Fresh reset, then a long morning level with both modules scheduled
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("r2_dup", 32'(dup), 0);
    s_m = 2'b11;
    mP  = 1'b1;
    tick();
    chk("mo_pend1", 32'(pend), 0);
    tick();
    chk("mo_pend2", 32'(pend), 32'h3);
    chk("mo_port2", 32'(port), 0);
    tick();
    chk("mo_port3", 32'(port), 32'h1);
    st0 = 1;
    st1 = 0;
    prv = port;
    for (int k = 4; k <= 35; k++) begin
      if (k == 20) mP = 1'b0;
      tick();
      if (port[0] && !prv[0]) st0++;
      if (port[1] && !prv[1]) st1++;
      prv = port;
      if (k == 10) chk("mo_port10", 32'(port), 0);
      if (k == 11) chk("mo_port11", 32'(port), 32'h2);
      chk($sformatf("mo_onehot@%0d", k), 32'(port != 2'b11), 1);
    end
    chk("mo_m0_doses", 32'(st0), 1);
    chk("mo_m1_doses", 32'(st1), 1);
    chk("mo_dup",      32'(dup),  0);
    chk("mo_pend_end", 32'(pend), 0);
    s_m = 2'b00;

    // Reset asserted in the middle of module 1 firing
    man = 2'b10;
    tick();
    man = 2'b00;
    tick();
    chk("mr_port2", 32'(port), 32'h2);
    man = 2'b01;
    tick();
    tick();
    man = 2'b00;
    chk("mr_port4", 32'(port), 32'h2);
    chk("mr_pend4", 32'(pend), 32'h1);
    chk("mr_dup4",  32'(dup),  1);
    rst_n = 1'b0;
    #1;
    chk("mr_port_rst", 32'(port), 0);
    chk("mr_pend_rst", 32'(pend), 0);
    chk("mr_busy_rst", 32'(busy), 0);
    chk("mr_dup_rst",  32'(dup),  0);
    @(negedge clk);
    rst_n = 1'b1;
    st0 = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (port != 2'b00 || busy) st0++;
    end
    chk("mr_quiet", 32'(st0), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dispense_scheduler.md
Name: dispense_scheduler

Overview:
- Sits between the dispense-time detector (morning/afternoon/evening slot signals) and the GPIO actuator pins of the pill-dispenser modules.
- Per-module schedule masks and manual requests become pending doses.
- Doses are served one at a time, round-robin, so only one actuator is ever energised. Each dose is a fixed-length pulse followed by a recovery gap.

Parameters:
NUM_MODULES, 2, number of dispenser modules / actuator outputs (2..8)
PULSE_CYCLES, 50000000, cycles an actuator output is held high per dose (1 s at 50 MHz)
GAP_CYCLES, 10000000, idle cycles after each dose before the next grant (>=1)
CNT_W, 31, width of the shared pulse/gap counter (must hold max(PULSE_CYCLES, GAP_CYCLES)-1)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
morningP  in  1  morning slot signal, level, may stay high many cycles
afternoonP  in  1  afternoon slot signal, level
eveningP  in  1  evening slot signal, level
sched_m  in  NUM_MODULES  bit i=1: module i doses in the morning slot
sched_a  in  NUM_MODULES  bit i=1: module i doses in the afternoon slot
sched_e  in  NUM_MODULES  bit i=1: module i doses in the evening slot
manual_req  in  NUM_MODULES  one-cycle manual dose request per module
port  out  NUM_MODULES  actuator drive, at most one bit high (one-hot or zero)
busy  out  1  high in FIRE or GAP
pending  out  NUM_MODULES  registered pending-dose flags
dup_err  out  1  sticky: a request hit an already-pending module

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; port=0, busy=0, pending=0, dup_err=0.
  - counter=0; rr pointer=0 (module 0 has highest priority first).
  - Slot edge registers=0.
- Slot edge detection: each slot input is registered once. A slot event is rising-edge only (current=1, previous=0), so a level held for 1 s yields one event.
- Request vector, per cycle: req = (mEdge ? sched_m : 0) | (aEdge ? sched_a : 0) | (eEdge ? sched_e : 0) | manual_req.
- Pending update:
  - pending[i] <= (pending[i] & ~clr[i]) | req[i]. A set in the same cycle as a clear wins.
  - dup_err <= 1 if any req[i] & pending[i] & ~clr[i]. A duplicate merges into the existing pending flag and is not queued twice.
- FSM states: IDLE, FIRE, GAP.
  - IDLE:
    - If pending != 0: grant g = first set bit searching from rr pointer upward with wrap-around.
    - clr[g]=1, counter<=0, port<=one-hot(g), rr pointer<=(g+1) mod NUM_MODULES, go to FIRE.
    - Otherwise stay, with port=0.
  - FIRE:
    - port holds one-hot(g); counter increments.
    - When counter==PULSE_CYCLES-1: port<=0, counter<=0, go to GAP.
    - port is high for exactly PULSE_CYCLES cycles.
  - GAP:
    - port=0; counter increments.
    - When counter==GAP_CYCLES-1: go to IDLE.
    - The next grant can issue in the IDLE cycle that follows, so there are exactly GAP_CYCLES+1 zero cycles between back-to-back doses.
- Latency:
  - manual_req at cycle t → pending visible at t+1 → port high from t+2 (if IDLE).
  - Slot input rising at t → edge at t+1 → pending at t+2 → port at t+3.
- Request during FIRE/GAP is queued in pending. This includes a request for the module currently firing, which is served again later.
- A module with sched bits set in multiple slots receives one dose per slot event.
- busy = (state != IDLE), registered with the state.
- Reset mid-pulse: port drops immediately (async), all pending doses are discarded.
- Counter arithmetic is unsigned CNT_W bits; compare with equality only. The counter never exceeds max(PULSE_CYCLES, GAP_CYCLES)-1.

Decomposition:
- Shared package dispense_pkg holds:
  - State encoding constants IDLE=2'b00, FIRE=2'b01, GAP=2'b10.
  - Default timing constants PULSE_1S=50000000 and GAP_200MS=10000000, shared with the clock/timer blocks.
- One sub-module, rr_arbiter (parameter N): inputs req[N-1:0] and ptr; outputs grant one-hot and grant index. It is purely combinational, with the pointer register kept in the parent.

Test Plan (NUM_MODULES=2, PULSE_CYCLES=4, GAP_CYCLES=3):
- Reset released, then manual_req=2'b01 for 1 cycle at t0 → pending=01 at t0+1; port=01 for cycles t0+2..t0+5; busy high t0+2..t0+8; port=00 after; pending=00.
- morningP held high for 20 cycles with sched_m=2'b11 → exactly one dose per module: module 0 first, then module 1. Second pulse starts 4 zero cycles after the first ends; dup_err=0.
- manual_req=2'b11 in one cycle, rr pointer=1 (after serving module 0) → module 1 fires first, then module 0.
- manual_req=2'b01 twice while pending[0]=1 and module 1 firing → dup_err=1 sticky; module 0 gets one dose only.
- manual_req[0] in the same cycle module 0 is granted → pending[0] stays 1; module 0 fires a second time after the gap.
- reset pulled low for 1 cycle mid-FIRE (port=10) → port=00, pending=00, busy=0, dup_err=0 immediately; no further pulses without new requests.
